// File: rtl/m24aa01_eeprom.sv
// ---------------------------------------------------------------------------
// m24aa01_eeprom
//   Behavioural model of a 24AA01-style 1 Kbit I2C serial EEPROM, written as
//   synthesizable logic clocked by a fast system clock that oversamples the
//   I2C bus. Supports byte/page writes with an 8-byte page buffer, current
//   address, random and sequential reads, write protect, and a timed
//   internal write cycle during which the device NACKs its control byte.
//
// Ports
//   clock   in   system clock (>= 8x SCL)
//   rst_n   in   asynchronous active-low reset
//   a0..a2  in   chip-select pins (not decoded)
//   wp      in   write protect, active high
//   scl_i   in   SCL as seen on the bus
//   sda_i   in   SDA as seen on the bus
//   sda_oe  out  1 = pull SDA low, 0 = release (open drain)
//   busy    out  high while an internal write cycle runs
// ---------------------------------------------------------------------------
module m24aa01_eeprom #(
  parameter int          MEM_DEPTH  = 128,
  parameter int          PAGE_SIZE  = 8,
  parameter int          TWC_CYCLES = 500000,
  parameter logic [7:0]  INIT_VALUE = 8'hFF
) (
  input  logic clock,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic wp,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy
);

  localparam int AW   = $clog2(MEM_DEPTH);
  localparam int OFFW = $clog2(PAGE_SIZE);
  localparam int CW   = (TWC_CYCLES > 1) ? $clog2(TWC_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_WORD_ADDR,
    S_WORD_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } state_t;

  // Chip-select pins have no function in this device.
  logic unused_pins;
  assign unused_pins = a0 ^ a1 ^ a2;

  // -------------------------------------------------------------------------
  // Bus synchronizers plus one extra stage used for edge detection.
  // -------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  // SDA may only change while SCL is low, except for START/STOP.
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q;
  logic [3:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic                rw_q;
  logic                master_ack_q;
  logic [AW-1:0]       pointer_q;
  logic                sda_oe_q;
  logic [PAGE_SIZE-1:0] valid_q;
  logic [7:0]          page_buf_q [PAGE_SIZE];
  logic [7:0]          mem_q [MEM_DEPTH];
  logic                busy_q;
  logic [CW-1:0]       busy_cnt_q;

  logic [7:0]          mem_rd;
  logic [AW-1:0]       ptr_inc;
  logic [OFFW-1:0]     ptr_off;
  logic [OFFW-1:0]     ptr_off_inc;
  logic                byte_done;
  logic                commit_d;

  assign mem_rd      = mem_q[pointer_q];
  assign ptr_inc     = (pointer_q == AW'(MEM_DEPTH - 1)) ? '0 : pointer_q + AW'(1);
  assign ptr_off     = pointer_q[OFFW-1:0];
  assign ptr_off_inc = ptr_off + OFFW'(1);
  // Eight bits have been shifted in and SCL has dropped: time for the ACK bit.
  assign byte_done   = scl_fall && (bit_cnt_q == 4'd8);

  // A clean STOP in WR_DATA arrives right after the SCL rise that precedes
  // it, so the bit counter reads 1 (or 0); anything larger is a STOP in the
  // middle of a byte, which aborts the write.
  assign commit_d = stop_det && (state_q == S_WR_DATA) && (bit_cnt_q <= 4'd1)
                    && (|valid_q) && !wp;

  // -------------------------------------------------------------------------
  // Protocol FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      master_ack_q <= 1'b0;
      pointer_q    <= '0;
      sda_oe_q     <= 1'b0;
      valid_q      <= '0;
      for (int i = 0; i < PAGE_SIZE; i++) begin
        page_buf_q[i] <= '0;
      end
    end else if (start_det) begin
      // Also handles repeated START; any buffered page data is discarded.
      state_q   <= S_DEV_ADDR;
      bit_cnt_q <= '0;
      sda_oe_q  <= 1'b0;
      valid_q   <= '0;
    end else if (stop_det) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sda_oe_q  <= 1'b0;
      valid_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_oe_q <= 1'b0;
        end

        S_DEV_ADDR: begin
          if (scl_rise) begin
            shift_q   <= {shift_q[6:0], sda_s2_q};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_q <= '0;
            if (shift_q[7:4] == 4'b1010 && !busy_q) begin
              sda_oe_q <= 1'b1;
              rw_q     <= shift_q[0];
              state_q  <= S_DEV_ACK;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end

        S_DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_q <= '0;
            if (rw_q) begin
              // Present the first read bit immediately after the ACK clock.
              shift_q  <= mem_rd;
              sda_oe_q <= ~mem_rd[7];
              state_q  <= S_RD_DATA;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= S_WORD_ADDR;
            end
          end
        end

        S_WORD_ADDR: begin
          if (scl_rise) begin
            shift_q   <= {shift_q[6:0], sda_s2_q};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_q <= '0;
            pointer_q <= shift_q[AW-1:0];
            sda_oe_q  <= 1'b1;
            state_q   <= S_WORD_ACK;
          end
        end

        S_WORD_ACK: begin
          if (scl_fall) begin
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            state_q   <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          if (scl_rise) begin
            shift_q   <= {shift_q[6:0], sda_s2_q};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_q           <= '0;
            page_buf_q[ptr_off] <= shift_q;
            valid_q[ptr_off]    <= 1'b1;
            // Only the in-page offset advances, so writes wrap in the page.
            pointer_q           <= {pointer_q[AW-1:OFFW], ptr_off_inc};
            sda_oe_q            <= 1'b1;
            state_q             <= S_WR_ACK;
          end
        end

        S_WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            state_q   <= S_WR_DATA;
          end
        end

        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_q  <= 1'b0;
              pointer_q <= ptr_inc;
              state_q   <= S_RD_ACK;
            end else begin
              sda_oe_q <= ~shift_q[6];
              shift_q  <= {shift_q[6:0], 1'b0};
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise) begin
            master_ack_q <= ~sda_s2_q;
          end else if (scl_fall) begin
            bit_cnt_q <= '0;
            if (master_ack_q) begin
              shift_q  <= mem_rd;
              sda_oe_q <= ~mem_rd[7];
              state_q  <= S_RD_DATA;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end

        default: begin
          state_q  <= S_IDLE;
          sda_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage array. Committed page bytes are written in one clock; the write
  // cycle timer below only models the device being unavailable.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= INIT_VALUE;
      end
    end else if (commit_d) begin
      for (int j = 0; j < PAGE_SIZE; j++) begin
        if (valid_q[j]) begin
          mem_q[{pointer_q[AW-1:OFFW], OFFW'(j)}] <= page_buf_q[j];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Internal write cycle timer: busy stays high for exactly TWC_CYCLES clocks.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      busy_cnt_q <= '0;
    end else if (commit_d) begin
      busy_q     <= 1'b1;
      busy_cnt_q <= CW'(TWC_CYCLES - 1);
    end else if (busy_q) begin
      if (busy_cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        busy_cnt_q <= busy_cnt_q - CW'(1);
      end
    end
  end

  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_m24aa01_eeprom.sv
// ---------------------------------------------------------------------------
// tb_m24aa01_eeprom
//   Directed bench for m24aa01_eeprom. A bit-banged I2C master drives SCL and
//   an open-drain SDA; each bus phase is a quarter period of 4 system clocks.
// ---------------------------------------------------------------------------
module tb_m24aa01_eeprom;

  localparam int TWC = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic wp    = 1'b0;
  logic scl   = 1'b1;
  logic m_low = 1'b0;
  logic sda_oe;
  logic busy;
  wire  sda_bus;

  assign sda_bus = ~(m_low | sda_oe);

  always #5 clk = ~clk;

  m24aa01_eeprom #(
    .MEM_DEPTH (128),
    .PAGE_SIZE (8),
    .TWC_CYCLES(TWC),
    .INIT_VALUE(8'hFF)
  ) dut (
    .clock (clk),
    .rst_n (rst_n),
    .a0    (1'b0),
    .a1    (1'b0),
    .a2    (1'b0),
    .wp    (wp),
    .scl_i (scl),
    .sda_i (sda_bus),
    .sda_oe(sda_oe),
    .busy  (busy)
  );

  int checks    = 0;
  int failures  = 0;
  int busy_run  = 0;
  int busy_len  = 0;

  logic       ack;
  logic [7:0] rd;
  logic [7:0] exp_page [8];

  // Length of the most recent busy pulse, in clocks.
  always @(posedge clk) begin
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      busy_len <= busy_run;
      busy_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (4) @(negedge clk);
  endtask

  task automatic i2c_start();
    q(); m_low = 1'b0; q(); scl = 1'b1; q(); m_low = 1'b1; q(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    q(); m_low = 1'b1; q(); scl = 1'b1; q(); m_low = 1'b0; q(); q();
  endtask

  task automatic wbit(input logic b);
    q(); m_low = ~b; q(); scl = 1'b1; q(); q(); scl = 1'b0;
  endtask

  task automatic rbit(output logic b);
    q(); m_low = 1'b0; q(); scl = 1'b1; q(); b = sda_bus; q(); scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic a);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    a = ~b;
    $display("tx write byte %02h ack=%0b", d, a);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~mack);
    $display("tx read byte %02h master_ack=%0b", d, mack);
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] d, input logic exp_ack);
    logic a;
    wbyte(d, a);
    chk(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  // Dummy write of the word address, repeated START, one byte read, NACK.
  task automatic random_read(input logic [6:0] a, output logic [7:0] d);
    i2c_start();
    wr_chk("rr_dev_ack", 8'hA0, 1'b1);
    wr_chk("rr_word_ack", {1'b0, a}, 1'b1);
    i2c_start();
    wr_chk("rr_rd_ack", 8'hA1, 1'b1);
    rbyte(d, 1'b0);
    i2c_stop();
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_page[0] = 8'h33; exp_page[1] = 8'hFF; exp_page[2] = 8'hFF; exp_page[3] = 8'hFF;
    exp_page[4] = 8'hFF; exp_page[5] = 8'hFF; exp_page[6] = 8'h11; exp_page[7] = 8'h22;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // Byte write 0x3C to address 5
    i2c_start();
    wr_chk("bw_dev_ack", 8'hA0, 1'b1);
    wr_chk("bw_word_ack", 8'h05, 1'b1);
    wr_chk("bw_data_ack", 8'h3C, 1'b1);
    i2c_stop();
    chk("bw_busy_high", {31'd0, busy}, 32'd1);

    // Control byte during the write cycle is not acknowledged
    i2c_start();
    wr_chk("busy_nack", 8'hA0, 1'b0);
    chk("busy_nack_released", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    wait_busy_low();
    chk("bw_busy_len", busy_len, TWC);

    // ACK polling succeeds, then random read of address 5
    random_read(7'd5, rd);
    chk("bw_readback", {24'd0, rd}, 32'h3C);

    // Reset during a write cycle restores the initial contents
    i2c_start();
    wr_chk("rst_dev_ack", 8'hA0, 1'b1);
    wr_chk("rst_word_ack", 8'h09, 1'b1);
    wr_chk("rst_data_ack", 8'h77, 1'b1);
    i2c_stop();
    chk("rst_busy_high", {31'd0, busy}, 32'd1);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy_cleared", {31'd0, busy}, 32'd0);
    random_read(7'd9, rd);
    chk("rst_addr9", {24'd0, rd}, 32'hFF);
    random_read(7'd5, rd);
    chk("rst_addr5", {24'd0, rd}, 32'hFF);

    // Page write wrapping inside page 0
    i2c_start();
    wr_chk("pw_dev_ack", 8'hA0, 1'b1);
    wr_chk("pw_word_ack", 8'h06, 1'b1);
    wr_chk("pw_d0_ack", 8'h11, 1'b1);
    wr_chk("pw_d1_ack", 8'h22, 1'b1);
    wr_chk("pw_d2_ack", 8'h33, 1'b1);
    i2c_stop();
    wait_busy_low();
    chk("pw_busy_len", busy_len, TWC);

    i2c_start();
    wr_chk("pr_dev_ack", 8'hA0, 1'b1);
    wr_chk("pr_word_ack", 8'h00, 1'b1);
    i2c_start();
    wr_chk("pr_rd_ack", 8'hA1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rbyte(rd, (i != 7));
      chk($sformatf("pr_byte%0d", i), {24'd0, rd}, {24'd0, exp_page[i]});
    end
    i2c_stop();

    // Current-address read after a random read of address 6
    random_read(7'd6, rd);
    chk("cr_addr6", {24'd0, rd}, 32'h11);
    i2c_start();
    wr_chk("cr_dev_ack", 8'hA1, 1'b1);
    rbyte(rd, 1'b0);
    i2c_stop();
    chk("cr_addr7", {24'd0, rd}, 32'h22);

    // Sequential read wraps from 127 to 0
    i2c_start();
    wr_chk("sw_dev_ack", 8'hA0, 1'b1);
    wr_chk("sw_word_ack", 8'h7F, 1'b1);
    i2c_start();
    wr_chk("sw_rd_ack", 8'hA1, 1'b1);
    rbyte(rd, 1'b1);
    chk("sw_addr127", {24'd0, rd}, 32'hFF);
    rbyte(rd, 1'b0);
    chk("sw_addr0", {24'd0, rd}, 32'h33);
    i2c_stop();

    // Write protect: bytes ACKed, nothing committed
    wp = 1'b1;
    i2c_start();
    wr_chk("wp_dev_ack", 8'hA0, 1'b1);
    wr_chk("wp_word_ack", 8'h02, 1'b1);
    wr_chk("wp_data_ack", 8'h55, 1'b1);
    i2c_stop();
    chk("wp_busy_low", {31'd0, busy}, 32'd0);
    wp = 1'b0;
    random_read(7'd2, rd);
    chk("wp_addr2", {24'd0, rd}, 32'hFF);

    // STOP in the middle of a byte aborts the whole write
    i2c_start();
    wr_chk("mb_dev_ack", 8'hA0, 1'b1);
    wr_chk("mb_word_ack", 8'h03, 1'b1);
    wr_chk("mb_data_ack", 8'h5A, 1'b1);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
    i2c_stop();
    $display("tx stop after 4 bits");
    chk("mb_busy_low", {31'd0, busy}, 32'd0);
    random_read(7'd3, rd);
    chk("mb_addr3", {24'd0, rd}, 32'hFF);

    // Bad control code: no ACK, ignored until next START
    i2c_start();
    wr_chk("bad_nack", 8'hB0, 1'b0);
    wr_chk("bad_idle_nack", 8'hA0, 1'b0);
    chk("bad_sda_released", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    i2c_start();
    wr_chk("bad_recover_ack", 8'hA0, 1'b1);
    i2c_stop();
    chk("bad_recover_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
